// File: rtl/btn_debounce3_pkg.sv
// Shared definitions for the three-channel button conditioner:
// per-channel FSM state encodings and the default debounce length.
package btn_debounce3_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        WAIT_HIGH = 2'b01,
        ST_HIGH   = 2'b11,
        WAIT_LOW  = 2'b10
    } db_state_e;

    // 10 ms at the 12 MHz board clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;

endpackage

// File: rtl/btn_debounce3_ch.sv
// One debounce channel: two-flop synchroniser, persistence counter and a
// four-state FSM producing a registered clean level plus rise/fall strobes.
module debounce_ch
    import btn_debounce3_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Counter only advances while s holds the candidate level; any reversal
    // returns to the stable state and the next attempt restarts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the upcoming state so they update on the accepting edge.
    always_comb begin
        dout_d = (state_d == ST_HIGH) || (state_d == WAIT_LOW);
        rise_d = (state_q == WAIT_HIGH) && (state_d == ST_HIGH);
        fall_d = (state_q == WAIT_LOW) && (state_d == ST_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/btn_debounce3.sv
// Three independent debounce channels feeding the AND gate inputs x0..x2
// (btn_db[i] -> xi) with per-channel edge strobes.
module btn_debounce3
    import btn_debounce3_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_in,
    output logic [2:0] btn_db,
    output logic [2:0] rise,
    output logic [2:0] fall
);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (btn_in[i]),
            .dout (btn_db[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce3.sv
// Self-checking bench for btn_debounce3 with a short debounce window:
// directed scenarios plus random bouncing against a run-length reference.
module tb_btn_debounce3;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_in;
    logic [2:0] btn_db;
    logic [2:0] rise;
    logic [2:0] fall;

    btn_debounce3 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_in(btn_in),
        .btn_db(btn_db),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference: a level is accepted once the synchronised input has
    // disagreed with the clean level for D+1 consecutive sampling edges.
    logic [2:0] m1, m2, expDb, expRise, expFall;
    int         run [3];

    int stepNo;
    int riseCnt [3];
    int riseStep[3];
    int fallCnt [3];
    int fallStep[3];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m1 = '0; m2 = '0; expDb = '0; expRise = '0; expFall = '0;
        for (int i = 0; i < 3; i++) run[i] = 0;
    endtask

    task automatic modelEdge();
        if (!rst_n) begin
            modelReset();
        end else begin
            expRise = '0;
            expFall = '0;
            for (int i = 0; i < 3; i++) begin
                if (m2[i] != expDb[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        expDb[i] = m2[i];
                        if (m2[i]) expRise[i] = 1'b1;
                        else       expFall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m2 = m1;
            m1 = btn_in;
        end
    endtask

    task automatic clearTrack();
        stepNo = 0;
        for (int i = 0; i < 3; i++) begin
            riseCnt[i] = 0; riseStep[i] = 0; fallCnt[i] = 0; fallStep[i] = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".btn_db"}, {29'd0, btn_db}, {29'd0, expDb});
        checkVal({tag, ".rise"},   {29'd0, rise},   {29'd0, expRise});
        checkVal({tag, ".fall"},   {29'd0, fall},   {29'd0, expFall});
    endtask

    task automatic applyStimulus(input logic [2:0] v, input string tag);
        btn_in = v;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
        stepNo++;
        for (int i = 0; i < 3; i++) begin
            if (rise[i] === 1'b1) begin riseCnt[i]++; riseStep[i] = stepNo; end
            if (fall[i] === 1'b1) begin fallCnt[i]++; fallStep[i] = stepNo; end
        end
    endtask

    logic [2:0] bounce [10];
    logic [2:0] rv;

    initial begin
        rst_n  = 1'b0;
        btn_in = 3'b111;
        modelReset();
        clearTrack();

        // Held in reset with all buttons pressed
        for (int k = 0; k < 3; k++) applyStimulus(3'b111, "inReset");

        // Release: held buttons are fresh presses accepted on edge 7
        rst_n = 1'b1;
        clearTrack();
        for (int k = 0; k < 10; k++) applyStimulus(3'b111, "resetRelease");
        for (int i = 0; i < 3; i++) begin
            checkVal("resetRiseStep", riseStep[i], 7);
            checkVal("resetRiseCnt",  riseCnt[i],  1);
        end

        // Release everything, settle low
        for (int k = 0; k < 10; k++) applyStimulus(3'b000, "releaseAll");
        checkVal("allLow", {29'd0, btn_db}, 32'd0);

        // Clean press and release on channel 0
        clearTrack();
        for (int k = 0; k < 10; k++) applyStimulus(3'b001, "press0");
        checkVal("press0RiseStep", riseStep[0], 7);
        checkVal("press0RiseCnt",  riseCnt[0],  1);
        clearTrack();
        for (int k = 0; k < 10; k++) applyStimulus(3'b000, "release0");
        checkVal("release0FallStep", fallStep[0], 7);
        checkVal("release0FallCnt",  fallCnt[0],  1);

        // Three-cycle glitch on channel 1
        clearTrack();
        for (int k = 0; k < 3; k++)  applyStimulus(3'b010, "glitch1");
        for (int k = 0; k < 10; k++) applyStimulus(3'b000, "glitch1");
        checkVal("glitch1RiseCnt", riseCnt[1], 0);
        checkVal("glitch1Db", {31'd0, btn_db[1]}, 32'd0);

        // Bounce on channel 2; final 0->1 sampled on edge 6
        bounce[0] = 3'b100; bounce[1] = 3'b000; bounce[2] = 3'b100; bounce[3] = 3'b100;
        bounce[4] = 3'b000; bounce[5] = 3'b100; bounce[6] = 3'b100; bounce[7] = 3'b100;
        bounce[8] = 3'b100; bounce[9] = 3'b100;
        clearTrack();
        for (int k = 0; k < 10; k++) applyStimulus(bounce[k], "bounce2");
        for (int k = 0; k < 4; k++)  applyStimulus(3'b100, "bounce2");
        checkVal("bounce2RiseCnt",  riseCnt[2],  1);
        checkVal("bounce2RiseStep", riseStep[2], 12);
        checkVal("bounce2FallCnt",  fallCnt[2],  0);

        for (int k = 0; k < 10; k++) applyStimulus(3'b000, "settle");

        // Channels 0 and 2 pressed two cycles apart
        clearTrack();
        applyStimulus(3'b001, "indep");
        applyStimulus(3'b001, "indep");
        for (int k = 0; k < 10; k++) applyStimulus(3'b101, "indep");
        checkVal("indepRise0Step", riseStep[0], 7);
        checkVal("indepRise2Step", riseStep[2], 9);
        checkVal("indepCh1Cnt",    riseCnt[1],  0);

        // Reset mid-WAIT_LOW while all three are high
        for (int k = 0; k < 10; k++) applyStimulus(3'b111, "allHigh");
        checkVal("allHigh", {29'd0, btn_db}, 32'd7);
        for (int k = 0; k < 5; k++)  applyStimulus(3'b000, "preReset");
        checkVal("preResetDb", {29'd0, btn_db}, 32'd7);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        checkVal("asyncResetDb", {29'd0, btn_db}, 32'd0);
        for (int k = 0; k < 2; k++) applyStimulus(3'b111, "heldReset");
        rst_n = 1'b1;
        clearTrack();
        for (int k = 0; k < 10; k++) applyStimulus(3'b111, "postReset");
        checkVal("postResetRiseStep", riseStep[1], 7);

        // Random bouncing on all channels
        rv = btn_in;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 6) == 0) rv[i] = ~rv[i];
            end
            applyStimulus(rv, "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
